// File: rtl/pipe_spawner.sv
// pipe_spawner
//   Pipe obstacle manager for the Flappy Bird playfield. It holds two pipe
//   slots and moves them on every game tick while the game is in RUN:
//   pipes that sit at column 0 are retired, the rest scroll one column left,
//   and every SPACING ticks a new pipe is spawned at the right edge. The gap
//   row of a new pipe comes from the free-running LFSR.
//
//   Ports
//     Clock, Reset  system clock; synchronous active-high reset
//     tick          one-cycle scroll strobe from the game timer
//     active        game running (0 = idle)
//     game_over     collision seen; pipes freeze until Reset
//     rnd[9:0]      LFSR value; only rnd[3:0] is used, sampled on spawn edges
//     pipe_v[1:0]   per-slot valid
//     pipe_x[7:0]   {slot1, slot0} pipe columns (0 when the slot is empty)
//     gap_top[7:0]  {slot1, slot0} top row of each gap (0 when the slot is empty)
//     score_p       one-cycle pulse when at least one pipe retires
//     score[6:0]    pipes passed, saturating at 99
//
//   Build option: define PIPE_SCORE_EN to enable the score counter; without
//   it, score is tied to zero and score_p still pulses.
module pipe_spawner #(
  parameter int COLS    = 16,
  parameter int ROWS    = 16,
  parameter int GAP_H   = 4,
  parameter int MARGIN  = 1,
  parameter int SPACING = 6
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       active,
  input  logic       game_over,
  input  logic [9:0] rnd,
  output logic [1:0] pipe_v,
  output logic [7:0] pipe_x,
  output logic [7:0] gap_top,
  output logic       score_p,
  output logic [6:0] score
);

  localparam int RANGE = ROWS - GAP_H - 2 * MARGIN + 1;
  localparam int CW    = (SPACING > 1) ? $clog2(SPACING) : 1;

  localparam logic [4:0]    RANGE_L  = 5'(RANGE);
  localparam logic [3:0]    MARGIN_L = 4'(MARGIN);
  localparam logic [3:0]    X_EDGE   = 4'(COLS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPACING - 1);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t state_q, state_d;

  logic [1:0]       v_q, v_d;
  logic [1:0][3:0]  x_q, x_d;
  logic [1:0][3:0]  g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             score_p_q, score_p_d;
  logic [1:0]       n_ret;
  logic [4:0]       r5, t5;
  logic [3:0]       new_gap;

  // Upper LFSR bits are intentionally ignored.
  logic unused_rnd;
  assign unused_rnd = ^rnd[9:4];

  // Fold the 4-bit random value into RANGE legal positions. RANGE >= 8
  // guarantees a single subtraction is enough.
  always_comb begin
    r5      = {1'b0, rnd[3:0]};
    t5      = (r5 >= RANGE_L) ? (r5 - RANGE_L) : r5;
    new_gap = t5[3:0] + MARGIN_L;
  end

  // ---------------- state register ----------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      v_q       <= '0;
      x_q       <= '0;
      g_q       <= '0;
      cnt_q     <= '0;
      score_p_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      x_q       <= x_d;
      g_q       <= g_d;
      cnt_q     <= cnt_d;
      score_p_q <= score_p_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active) state_d = RUN;
      RUN: begin
        if (game_over)    state_d = FROZEN;   // beats a same-cycle tick
        else if (!active) state_d = IDLE;
      end
      FROZEN:  state_d = FROZEN;              // only Reset leaves
      default: state_d = IDLE;
    endcase
  end

  // ---------------- slot datapath ----------------
  always_comb begin
    v_d       = v_q;
    x_d       = x_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    score_p_d = 1'b0;
    n_ret     = '0;
    if (state_q == RUN && !game_over) begin
      if (!active) begin
        v_d   = '0;
        x_d   = '0;
        g_d   = '0;
        cnt_d = '0;
      end else if (tick) begin
        // Retire pipes at column 0, scroll the rest.
        for (int i = 0; i < 2; i++) begin
          if (v_q[i]) begin
            if (x_q[i] == 4'd0) begin
              v_d[i] = 1'b0;
              x_d[i] = 4'd0;
              g_d[i] = 4'd0;
              n_ret  = n_ret + 2'd1;
            end else begin
              x_d[i] = x_q[i] - 4'd1;
            end
          end
        end
        score_p_d = (n_ret != 2'd0);
        // Spawn into the lowest free slot; slots just retired count as free.
        // With no free slot the counter parks at its last value so the
        // spawn is retried on every following tick.
        if (cnt_q == CNT_LAST) begin
          if (!v_d[0]) begin
            v_d[0] = 1'b1;
            x_d[0] = X_EDGE;
            g_d[0] = new_gap;
            cnt_d  = '0;
          end else if (!v_d[1]) begin
            v_d[1] = 1'b1;
            x_d[1] = X_EDGE;
            g_d[1] = new_gap;
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

`ifdef PIPE_SCORE_EN
  logic [6:0] score_q, score_d, score_sum;

  always_comb begin
    score_sum = score_q + {5'd0, n_ret};
    score_d   = score_q;
    if (state_q == RUN && !game_over) begin
      if (!active)     score_d = '0;
      else if (tick)   score_d = (score_sum > 7'd99) ? 7'd99 : score_sum;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 7'd0;
`endif

  // ---------------- outputs ----------------
  // Cleared slots hold zero x/gap, so the registers drive the ports directly.
  always_comb begin
    pipe_v  = v_q;
    pipe_x  = {x_q[1], x_q[0]};
    gap_top = {g_q[1], g_q[0]};
    score_p = score_p_q;
  end

endmodule

// File: tb/tb_pipe_spawner.sv
module tb_pipe_spawner;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       tick;
  logic       active;
  logic       game_over;
  logic [9:0] rnd;
  logic [1:0] pipe_v;
  logic [7:0] pipe_x;
  logic [7:0] gap_top;
  logic       score_p;
  logic [6:0] score;

  int checks = 0;
  int errors = 0;

  pipe_spawner dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .tick      (tick),
    .active    (active),
    .game_over (game_over),
    .rnd       (rnd),
    .pipe_v    (pipe_v),
    .pipe_x    (pipe_x),
    .gap_top   (gap_top),
    .score_p   (score_p),
    .score     (score)
  );

  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick = 1'b0; active = 1'b0; game_over = 1'b0; rnd = '0;
    step();
    Reset = 1'b0;
  endtask

  task automatic start_run();
    active = 1'b1;
    step();
  endtask

  task automatic tick_n(input int n, input logic [9:0] r);
    for (int i = 0; i < n; i++) begin
      rnd = r; tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick = 1'b1; active = 1'b1; game_over = 1'b0; rnd = 10'h3FF;
    step();
    Reset = 1'b0; tick = 1'b0; active = 1'b0;
    checks++;
    if ({pipe_v, pipe_x, gap_top, score_p, score} !== 26'd0) begin
      errors++;
      $display("FAIL reset: v=%b x=%h gap=%h sp=%b score=%0d want all 0",
               pipe_v, pipe_x, gap_top, score_p, score);
    end
  endtask

  task automatic test_first_spawn();
    do_reset();
    start_run();
    tick_n(5, 10'h005);
    checks++;
    if (pipe_v !== 2'b00) begin
      errors++; $display("FAIL pre_spawn: v=%b want 00", pipe_v);
    end
    tick_n(1, 10'h3F5);
    checks++;
    if (pipe_v !== 2'b01 || pipe_x !== 8'h0F || gap_top !== 8'h06) begin
      errors++;
      $display("FAIL first_spawn: v=%b x=%h gap=%h want 01 0f 06", pipe_v, pipe_x, gap_top);
    end
  endtask

  task automatic test_gap_map();
    logic [3:0] rv [3] = '{4'd0, 4'd13, 4'd15};
    logic [3:0] ev [3] = '{4'd1, 4'd3, 4'd5};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      start_run();
      tick_n(5, 10'h3FF);
      tick_n(1, {6'h2A, rv[k]});
      checks++;
      if (gap_top !== {4'h0, ev[k]}) begin
        errors++;
        $display("FAIL gap_map r=%0d: gap=%h want %h", rv[k], gap_top, {4'h0, ev[k]});
      end
    end
  endtask

  task automatic test_scroll_retire();
    do_reset();
    start_run();
    tick_n(6, 10'h005);             // slot0 spawned, gap 6
    tick_n(6, 10'h009);             // slot1 spawned on tick 12, gap 10
    checks++;
    if (pipe_v !== 2'b11 || pipe_x !== 8'hF9 || gap_top !== 8'hA6) begin
      errors++;
      $display("FAIL second_spawn: v=%b x=%h gap=%h want 11 f9 a6", pipe_v, pipe_x, gap_top);
    end
    tick_n(6, 10'h003);             // tick 18: both slots busy, spawn skipped
    checks++;
    if (pipe_v !== 2'b11 || pipe_x !== 8'h93 || gap_top !== 8'hA6) begin
      errors++;
      $display("FAIL spawn_skip: v=%b x=%h gap=%h want 11 93 a6", pipe_v, pipe_x, gap_top);
    end
    tick_n(3, 10'h003);             // tick 21: slot0 at column 0
    checks++;
    if (pipe_x !== 8'h60 || score_p !== 1'b0) begin
      errors++;
      $display("FAIL at_col0: x=%h sp=%b want 60 0", pipe_x, score_p);
    end
    tick_n(1, 10'h000);             // tick 22: retire slot0 and respawn there
    checks++;
    if (pipe_v !== 2'b11 || pipe_x !== 8'h5F || gap_top !== 8'hA1 || score_p !== 1'b1) begin
      errors++;
      $display("FAIL retire_respawn: v=%b x=%h gap=%h sp=%b want 11 5f a1 1",
               pipe_v, pipe_x, gap_top, score_p);
    end
    checks++;
`ifdef PIPE_SCORE_EN
    if (score !== 7'd1) begin
      errors++; $display("FAIL score: got %0d want 1", score);
    end
`else
    if (score !== 7'd0) begin
      errors++; $display("FAIL score_tied: got %0d want 0", score);
    end
`endif
    step();
    checks++;
    if (score_p !== 1'b0 || pipe_x !== 8'h5F) begin
      errors++; $display("FAIL pulse_width: sp=%b x=%h want 0 5f", score_p, pipe_x);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    start_run();
    tick_n(6, 10'h005);
    game_over = 1'b1;
    tick_n(1, 10'h005);
    game_over = 1'b0;
    checks++;
    if (pipe_v !== 2'b01 || pipe_x !== 8'h0F) begin
      errors++; $display("FAIL freeze_tick: v=%b x=%h want 01 0f", pipe_v, pipe_x);
    end
    active = 1'b0;
    tick_n(3, 10'h005);
    active = 1'b1;
    tick_n(8, 10'h005);
    checks++;
    if (pipe_v !== 2'b01 || pipe_x !== 8'h0F || gap_top !== 8'h06) begin
      errors++;
      $display("FAIL frozen_hold: v=%b x=%h gap=%h want 01 0f 06", pipe_v, pipe_x, gap_top);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0; active = 1'b0;
    checks++;
    if ({pipe_v, pipe_x, gap_top} !== 18'd0) begin
      errors++; $display("FAIL freeze_reset: v=%b x=%h gap=%h want 0", pipe_v, pipe_x, gap_top);
    end
  endtask

  task automatic test_idle_restart();
    do_reset();
    start_run();
    tick_n(8, 10'h005);
    active = 1'b0;
    step();
    checks++;
    if ({pipe_v, pipe_x, gap_top} !== 18'd0) begin
      errors++; $display("FAIL run_to_idle: v=%b x=%h gap=%h want 0", pipe_v, pipe_x, gap_top);
    end
    tick_n(7, 10'h005);             // ticks in IDLE ignored
    active = 1'b1;
    tick_n(1, 10'h007);             // tick on the entry edge is also ignored
    tick_n(5, 10'h007);
    checks++;
    if (pipe_v !== 2'b00) begin
      errors++; $display("FAIL idle_cnt_clear: v=%b want 00", pipe_v);
    end
    tick_n(1, 10'h007);
    checks++;
    if (pipe_v !== 2'b01 || pipe_x !== 8'h0F || gap_top !== 8'h08) begin
      errors++;
      $display("FAIL restart_spawn: v=%b x=%h gap=%h want 01 0f 08", pipe_v, pipe_x, gap_top);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_run();
    tick_n(13, 10'h005);
    checks++;
    if (pipe_v !== 2'b11 || pipe_x !== 8'hE8) begin
      errors++; $display("FAIL mid_run_state: v=%b x=%h want 11 e8", pipe_v, pipe_x);
    end
    Reset = 1'b1; tick = 1'b1;
    step();
    Reset = 1'b0; tick = 1'b0; active = 1'b0;
    checks++;
    if ({pipe_v, pipe_x, gap_top, score_p, score} !== 26'd0) begin
      errors++;
      $display("FAIL mid_run_reset: v=%b x=%h gap=%h sp=%b score=%0d want 0",
               pipe_v, pipe_x, gap_top, score_p, score);
    end
    tick_n(6, 10'h005);             // still IDLE: no spawn
    checks++;
    if (pipe_v !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle: v=%b want 00", pipe_v);
    end
  endtask

  initial begin
    Reset = 1'b1; tick = 1'b0; active = 1'b0; game_over = 1'b0; rnd = '0;
    step();
    test_reset();
    test_first_spawn();
    test_gap_map();
    test_scroll_retire();
    test_freeze();
    test_idle_restart();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
